// File: rtl/fpu_operand_loader.sv
// Byte-serial operand loader and result catcher for the fpu block.
// Assembles A/B from an 8-bit stream, updates both operands on one edge, then captures the result after FPU_LATENCY edges.
module fpu_operand_loader #(
    parameter int FPU_LATENCY = 4
) (
    input  logic        clock100KHz,
    input  logic        reset,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [31:0] op_A_out,
    output logic [31:0] op_B_out,
    input  logic [31:0] fpu_data_in,
    input  logic [3:0]  fpu_status_in,
    output logic [31:0] result_out,
    output logic [3:0]  status_out,
    output logic        result_valid,
    input  logic        result_ack
);

    typedef enum logic [1:0] {
        LOAD_A  = 2'd0,
        LOAD_B  = 2'd1,
        WAIT    = 2'd2,
        PRESENT = 2'd3
    } state_t;

    localparam logic [7:0] WAIT_INIT = 8'(FPU_LATENCY - 1);

    state_t      state_r;
    state_t      next_state_s;
    logic [1:0]  byte_cnt_r;
    logic [31:0] shadow_a_r;
    logic [31:0] shadow_b_r;
    logic [7:0]  wait_cnt_r;
    logic [31:0] op_a_r;
    logic [31:0] op_b_r;
    logic [31:0] result_r;
    logic [3:0]  status_r;
    logic        result_valid_r;

    logic        byte_ready_s;
    logic        xfer_s;
    logic        last_byte_s;
    logic        load_a_done_s;
    logic        load_b_done_s;
    logic        wait_done_s;
    logic        ack_take_s;

    // State register
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            state_r <= LOAD_A;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            LOAD_A: begin
                if (load_a_done_s) begin
                    next_state_s = LOAD_B;
                end else begin
                    next_state_s = LOAD_A;
                end
            end
            LOAD_B: begin
                if (load_b_done_s) begin
                    next_state_s = WAIT;
                end else begin
                    next_state_s = LOAD_B;
                end
            end
            WAIT: begin
                if (wait_done_s) begin
                    next_state_s = PRESENT;
                end else begin
                    next_state_s = WAIT;
                end
            end
            PRESENT: begin
                if (ack_take_s) begin
                    next_state_s = LOAD_A;
                end else begin
                    next_state_s = PRESENT;
                end
            end
            default: next_state_s = LOAD_A;
        endcase
    end

    // Output and control decode from state
    always_comb begin
        byte_ready_s  = 1'b0;
        wait_done_s   = 1'b0;
        ack_take_s    = 1'b0;
        case (state_r)
            LOAD_A:  byte_ready_s = 1'b1;
            LOAD_B:  byte_ready_s = 1'b1;
            WAIT:    wait_done_s  = (wait_cnt_r == 8'd0);
            PRESENT: ack_take_s   = result_ack;
            default: byte_ready_s = 1'b0;
        endcase
        xfer_s        = byte_valid & byte_ready_s;
        last_byte_s   = xfer_s & (byte_cnt_r == 2'd3);
        load_a_done_s = last_byte_s & (state_r == LOAD_A);
        load_b_done_s = last_byte_s & (state_r == LOAD_B);
    end

    // Byte counter and operand shadow registers; the counter wraps naturally at 4 bytes
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            byte_cnt_r <= 2'd0;
            shadow_a_r <= 32'd0;
            shadow_b_r <= 32'd0;
        end else if (xfer_s) begin
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (state_r == LOAD_A) begin
                shadow_a_r <= {shadow_a_r[23:0], byte_in};
            end else begin
                shadow_b_r <= {shadow_b_r[23:0], byte_in};
            end
        end else begin
            byte_cnt_r <= byte_cnt_r;
        end
    end

    // Both operands update together on the final B byte so the FPU never sees a mixed pair
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            op_a_r <= 32'd0;
            op_b_r <= 32'd0;
        end else if (load_b_done_s) begin
            op_a_r <= shadow_a_r;
            op_b_r <= {shadow_b_r[23:0], byte_in};
        end else begin
            op_a_r <= op_a_r;
        end
    end

    // Latency countdown between operand update and result sampling
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            wait_cnt_r <= 8'd0;
        end else if (load_b_done_s) begin
            wait_cnt_r <= WAIT_INIT;
        end else if ((state_r == WAIT) && !wait_done_s) begin
            wait_cnt_r <= wait_cnt_r - 8'd1;
        end else begin
            wait_cnt_r <= wait_cnt_r;
        end
    end

    // Result capture and valid/ack handshake; data is held until the next capture
    always_ff @(posedge clock100KHz or negedge reset) begin
        if (!reset) begin
            result_r       <= 32'd0;
            status_r       <= 4'd0;
            result_valid_r <= 1'b0;
        end else if (wait_done_s) begin
            result_r       <= fpu_data_in;
            status_r       <= fpu_status_in;
            result_valid_r <= 1'b1;
        end else if (ack_take_s) begin
            result_valid_r <= 1'b0;
        end else begin
            result_valid_r <= result_valid_r;
        end
    end

    assign byte_ready   = byte_ready_s;
    assign op_A_out     = op_a_r;
    assign op_B_out     = op_b_r;
    assign result_out   = result_r;
    assign status_out   = status_r;
    assign result_valid = result_valid_r;

endmodule

// File: tb/tb_fpu_operand_loader.sv
// Directed bench for fpu_operand_loader: latency-4 instance for the main flow and a latency-1 instance for the minimum case.
module tb_fpu_operand_loader;

    logic        clk = 1'b0;
    logic        reset, reset1;
    logic [7:0]  byte_in;
    logic        byte_valid, byte_valid1;
    logic        byte_ready, byte_ready1;
    logic [31:0] op_a, op_b, op_a1, op_b1;
    logic [31:0] fpu_data;
    logic [3:0]  fpu_status;
    logic [31:0] result, result1;
    logic [3:0]  status, status1;
    logic        result_valid, result_valid1;
    logic        result_ack, result_ack1;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    fpu_operand_loader #(.FPU_LATENCY(4)) dut (
        .clock100KHz(clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .op_A_out(op_a), .op_B_out(op_b),
        .fpu_data_in(fpu_data), .fpu_status_in(fpu_status), .result_out(result),
        .status_out(status), .result_valid(result_valid), .result_ack(result_ack)
    );

    fpu_operand_loader #(.FPU_LATENCY(1)) dut1 (
        .clock100KHz(clk), .reset(reset1), .byte_in(byte_in), .byte_valid(byte_valid1),
        .byte_ready(byte_ready1), .op_A_out(op_a1), .op_B_out(op_b1),
        .fpu_data_in(fpu_data), .fpu_status_in(fpu_status), .result_out(result1),
        .status_out(status1), .result_valid(result_valid1), .result_ack(result_ack1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one byte to the selected instance and returns 1 time unit after the accepting edge.
    task automatic send_byte(input int sel, input logic [7:0] b);
        logic rdy;
        int   n;
        byte_in = b;
        if (sel == 0) byte_valid = 1'b1;
        else          byte_valid1 = 1'b1;
        n = 0;
        do begin
            rdy = (sel == 0) ? byte_ready : byte_ready1;
            tick();
            n++;
        end while (!rdy && n < 50);
        if (!rdy) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input int sel, input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int i = 0; i < 4; i++) begin
            send_byte(sel, t[31:24]);
            t = t << 8;
        end
    endtask

    logic [7:0] basic_bytes [8];

    initial begin
        basic_bytes = '{8'h3F, 8'h80, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00};
        reset = 1'b1; reset1 = 1'b0;
        byte_in = 8'h00; byte_valid = 1'b0; byte_valid1 = 1'b0;
        result_ack = 1'b0; result_ack1 = 1'b0;
        fpu_data = 32'hDEADBEEF; fpu_status = 4'hA;

        // Reset with a byte presented
        #2;
        reset = 1'b0; byte_valid = 1'b1; byte_in = 8'hFF;
        #1;
        check("rst_async_ready", {31'd0, byte_ready}, 32'd1);
        tick(); tick(); tick();
        check("rst_op_a", op_a, 32'd0);
        check("rst_op_b", op_b, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_status", {28'd0, status}, 32'd0);
        check("rst_valid", {31'd0, result_valid}, 32'd0);
        check("rst_ready", {31'd0, byte_ready}, 32'd1);
        byte_valid = 1'b0;
        reset = 1'b1;
        tick();

        // Basic back-to-back load, latency 4
        for (int i = 0; i < 7; i++) begin
            send_byte(0, basic_bytes[i]);
            check("basic_op_a_held", op_a, 32'd0);
        end
        send_byte(0, basic_bytes[7]);
        byte_valid = 1'b0;
        fpu_data = 32'h40400000; fpu_status = 4'b0001;
        check("basic_op_a", op_a, 32'h3F800000);
        check("basic_op_b", op_b, 32'h40000000);
        check("basic_ready_wait", {31'd0, byte_ready}, 32'd0);
        tick(); tick(); tick();
        check("basic_valid_early", {31'd0, result_valid}, 32'd0);
        tick();
        check("basic_valid", {31'd0, result_valid}, 32'd1);
        check("basic_result", result, 32'h40400000);
        check("basic_status", {28'd0, status}, 32'd1);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        check("basic_ack_valid", {31'd0, result_valid}, 32'd0);
        check("basic_ack_ready", {31'd0, byte_ready}, 32'd1);

        // Gapped input, same bytes
        fpu_data = 32'h00000000; fpu_status = 4'hF;
        for (int i = 0; i < 8; i++) begin
            send_byte(0, basic_bytes[i]);
            byte_valid = 1'b0;
            if (i < 7) begin
                check("gap_ready", {31'd0, byte_ready}, 32'd1);
                tick();
            end
        end
        fpu_data = 32'h40400000; fpu_status = 4'b0001;
        check("gap_op_a", op_a, 32'h3F800000);
        check("gap_op_b", op_b, 32'h40000000);
        tick(); tick(); tick(); tick();
        check("gap_valid", {31'd0, result_valid}, 32'd1);
        check("gap_result", result, 32'h40400000);
        check("gap_status", {28'd0, status}, 32'd1);

        // Backpressure: bytes presented while the result is unacknowledged
        byte_in = 8'hAA; byte_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", {31'd0, result_valid}, 32'd1);
            check("bp_ready", {31'd0, byte_ready}, 32'd0);
        end
        check("bp_op_a", op_a, 32'h3F800000);
        check("bp_op_b", op_b, 32'h40000000);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        byte_valid = 1'b0;
        check("bp_ack_valid", {31'd0, result_valid}, 32'd0);
        check("bp_ack_ready", {31'd0, byte_ready}, 32'd1);
        check("bp_ack_result", result, 32'h40400000);

        // The AA byte on the ack edge must not have entered shadow A
        send_word(0, 32'hCAFEF00D);
        send_word(0, 32'h01020304);
        byte_valid = 1'b0;
        check("post_ack_op_a", op_a, 32'hCAFEF00D);
        check("post_ack_op_b", op_b, 32'h01020304);
        tick(); tick(); tick(); tick();
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;

        // Reset mid-load of B
        send_word(0, 32'hA1A2A3A4);
        send_byte(0, 8'hB1);
        send_byte(0, 8'hB2);
        byte_valid = 1'b0;
        reset = 1'b0;
        #1;
        check("midrst_op_a", op_a, 32'd0);
        check("midrst_op_b", op_b, 32'd0);
        check("midrst_ready", {31'd0, byte_ready}, 32'd1);
        tick();
        reset = 1'b1;
        tick();
        send_word(0, 32'h11223344);
        send_word(0, 32'h55667788);
        byte_valid = 1'b0;
        check("midrst_new_a", op_a, 32'h11223344);
        check("midrst_new_b", op_b, 32'h55667788);

        // Minimum latency instance
        reset1 = 1'b1;
        fpu_data = 32'h00000000; fpu_status = 4'h0;
        tick();
        send_word(1, 32'h40A00000);
        send_word(1, 32'h3F800000);
        byte_valid1 = 1'b0;
        check("lat1_op_a", op_a1, 32'h40A00000);
        check("lat1_op_b", op_b1, 32'h3F800000);
        check("lat1_valid_k", {31'd0, result_valid1}, 32'd0);
        fpu_data = 32'hC0A00000; fpu_status = 4'b0100;
        tick();
        check("lat1_valid", {31'd0, result_valid1}, 32'd1);
        check("lat1_result", result1, 32'hC0A00000);
        check("lat1_status", {28'd0, status1}, 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
